// File: rtl/mem_pkg.sv
// Shared types for the ktc32 memory path: size/write-enable codes, port ids, arbiter states.
package mem_pkg;
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;
endpackage

// File: rtl/mem_arbiter_load_ext.sv
// Combinational load size/sign extension from the low bits of a RAM word.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);
    always_comb begin
        result = rd;
        case (size)
            SZ_BYTE: result = {{24{~uns & rd[7]}}, rd[7:0]};
            SZ_HALF: result = {{16{~uns & rd[15]}}, rd[15:0]};
            default: result = rd;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM/IO block between instruction fetch and load/store.
// Each granted access runs IDLE -> ACCESS -> DONE, acking in DONE.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit RESET_LAST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [1:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    state_e      state;
    port_e       last_port;
    port_e       gnt_port;
    logic        gnt_store;
    logic [1:0]  gnt_size;
    logic        gnt_uns;
    logic [1:0]  we_q;
    logic [31:0] ext_rd;
    logic        grant_data;
    logic [1:0]  d_size_n;

    assign d_size_n = (d_size == SZ_NONE) ? SZ_WORD : d_size;

    // Data wins when alone, when priority is fixed, or when fetch had the last grant.
    assign grant_data = d_req & (~i_req | ~ROUND_ROBIN | (last_port == PORT_FETCH));

    // Reset masks the write strobe so a reset landing in ACCESS never writes.
    assign mem_we = rst ? SZ_NONE : we_q;

    load_ext u_load_ext (
        .rd     (mem_rd),
        .size   (gnt_size),
        .uns    (gnt_uns),
        .result (ext_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_port <= port_e'(RESET_LAST);
            gnt_port  <= PORT_FETCH;
            gnt_store <= 1'b0;
            gnt_size  <= SZ_WORD;
            gnt_uns   <= 1'b0;
            we_q      <= SZ_NONE;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (grant_data) begin
                        state     <= ACCESS;
                        last_port <= PORT_DATA;
                        gnt_port  <= PORT_DATA;
                        gnt_store <= d_we;
                        gnt_size  <= d_size_n;
                        gnt_uns   <= d_unsigned;
                        we_q      <= d_we ? d_size_n : SZ_NONE;
                        mem_addr  <= d_addr;
                        mem_wd    <= d_wdata;
                    end else if (i_req) begin
                        state     <= ACCESS;
                        last_port <= PORT_FETCH;
                        gnt_port  <= PORT_FETCH;
                        gnt_store <= 1'b0;
                        gnt_size  <= SZ_WORD;
                        gnt_uns   <= 1'b0;
                        we_q      <= SZ_NONE;
                        mem_addr  <= i_addr;
                        mem_wd    <= '0;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    we_q  <= SZ_NONE;
                    if (gnt_port == PORT_FETCH) begin
                        i_ack   <= 1'b1;
                        i_rdata <= mem_rd;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= gnt_store ? 32'h0 : ext_rd;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a small byte RAM model.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_req, i_ack, d_req, d_we, d_unsigned, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wd, mem_rd;
    logic [1:0]  d_size, mem_we;

    logic        rst0, i_req0, i_ack0, d_req0, d_ack0;
    logic [31:0] i_rdata0, d_rdata0, mem_addr0, mem_wd0;
    logic [1:0]  d_size0, mem_we0;
    logic [31:0] mem_rd0 = 32'h55AA_80FF;

    mem_arbiter #(.ROUND_ROBIN(1'b1), .RESET_LAST(1'b0)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.ROUND_ROBIN(1'b0), .RESET_LAST(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .i_req(i_req0), .i_addr(32'h0000_0040), .i_ack(i_ack0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_we(1'b0), .d_size(d_size0), .d_unsigned(1'b0), .d_addr(32'h0000_0030),
        .d_wdata(32'h0), .d_ack(d_ack0), .d_rdata(d_rdata0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wd(mem_wd0), .mem_rd(mem_rd0)
    );

    // Byte RAM, little-endian, indexed by the low address byte.
    logic [7:0] ram [0:255];
    logic       tb_init;
    logic [7:0] ra;
    assign ra = mem_addr[7:0];
    assign mem_rd = {ram[8'(ra + 8'd3)], ram[8'(ra + 8'd2)], ram[8'(ra + 8'd1)], ram[ra]};

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h10] <= 8'hEF; ram[8'h11] <= 8'hBE; ram[8'h12] <= 8'hAD; ram[8'h13] <= 8'hDE;
        end else if (mem_we != 2'b00) begin
            ram[ra] <= mem_wd[7:0];
            if (mem_we >= 2'b10) ram[8'(ra + 8'd1)] <= mem_wd[15:8];
            if (mem_we == 2'b11) begin
                ram[8'(ra + 8'd2)] <= mem_wd[23:16];
                ram[8'(ra + 8'd3)] <= mem_wd[31:24];
            end
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [1:0]  exp_we;
    } vec_t;

    // Called at a falling edge with the arbiter in IDLE; returns at the next IDLE falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        int         ack_cyc;
        int         we_cnt;
        logic [1:0] we_seen;
        logic       other;
        logic [31:0] rdat;
        ack_cyc = -1; we_cnt = 0; we_seen = 2'b00; other = 1'b0; rdat = '0;
        if (v.fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
            d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we != 2'b00) begin we_cnt++; we_seen = mem_we; end
            if (k == 1) begin
                chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
                if (!v.fetch && v.we) chk($sformatf("v%0d_wd", idx), mem_wd, v.wdata);
            end
            if (v.fetch ? d_ack : i_ack) other = 1'b1;
            if (v.fetch ? i_ack : d_ack) begin
                ack_cyc = k;
                rdat = v.fetch ? i_rdata : d_rdata;
                i_req = 1'b0; d_req = 1'b0;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk($sformatf("v%0d_ack_latency", idx), 32'(ack_cyc), 32'd2);
        chk($sformatf("v%0d_rdata", idx), rdat, v.exp_rd);
        chk($sformatf("v%0d_we_code", idx), {30'd0, we_seen}, {30'd0, v.exp_we});
        chk($sformatf("v%0d_we_cycles", idx), 32'(we_cnt), (v.exp_we != 2'b00) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_other_ack", idx), {31'd0, other}, 32'd0);
        @(negedge clk);
    endtask

    vec_t vecs [12];
    logic [15:0] imask, dmask;

    initial begin
        //         fetch we   size   uns   addr          wdata         exp_rd        exp_we
        vecs[0]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'h0000_00F0, 32'h0,        2'b01};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,        32'hFFFF_FFF0, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,        32'h0000_00F0, 2'b00};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0030, 32'h8001_A5C3, 32'h0,        2'b11};
        vecs[5]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        32'hFFFF_A5C3, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0032, 32'h0,        32'h0000_8001, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0,        32'h8001_A5C3, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_7FFF, 32'h0,        2'b10};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        32'h0000_7FFF, 2'b00};
        vecs[10] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        32'h0000_7FFF, 2'b00};
        vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'hFFF0_0000, 32'h0000_000A, 32'h0,        2'b11};

        rst = 1'b1; rst0 = 1'b1; tb_init = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b11;
        d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
        i_req0 = 1'b0; d_req0 = 1'b0; d_size0 = 2'b01;
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_we", {30'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 12; n++) run_vec(vecs[n], n);

        // Round-robin conflict from reset release: data first, then strict alternation.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_unsigned = 1'b0; d_addr = 32'h30;
        @(negedge clk);
        rst = 1'b0;
        imask = '0; dmask = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            imask[k] = i_ack; dmask[k] = d_ack;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("rr_d_ack_cycles", {16'd0, dmask}, 32'h0000_0104);
        chk("rr_i_ack_cycles", {16'd0, imask}, 32'h0000_0820);
        chk("rr_d_rdata", d_rdata, 32'h8001_A5C3);
        chk("rr_i_rdata", i_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Reset during ACCESS of a word store to 0x10: no write, no ack.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 32'h10; d_wdata = 32'h1111_1111;
        @(negedge clk);
        chk("midrst_pre_we", {30'd0, mem_we}, 32'd3);
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("midrst_we_forced", {30'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("midrst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("midrst_outs", mem_addr | mem_wd | i_rdata | d_rdata | {30'd0, mem_we}, 32'd0);
        rst = 1'b0;
        run_vec('{1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00}, 99);

        // Fixed priority: data starves fetch until d_req drops.
        i_req0 = 1'b1; d_req0 = 1'b1; rst0 = 1'b0;
        imask = '0; dmask = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            imask[k] = i_ack0; dmask[k] = d_ack0;
            if (k == 11) d_req0 = 1'b0;
        end
        i_req0 = 1'b0;
        chk("fp_d_ack_cycles", {16'd0, dmask}, 32'h0000_0924);
        chk("fp_i_ack_cycles", {16'd0, imask}, 32'h0000_4000);
        chk("fp_d_rdata", d_rdata0, 32'hFFFF_FFFF);
        chk("fp_i_rdata", i_rdata0, 32'h55AA_80FF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
